// File: rtl/mem_arb.sv
// Two-master (instruction fetch / data) arbiter in front of a single-port synchronous RAM.
// Define MEM_ARB_RR_EN to arbitrate simultaneous requests round-robin instead of data-first.
module mem_arb #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [WIDTH-1:0] if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [WIDTH-1:0] d_rdata,
    output logic [WIDTH-1:0] mem_ad,
    output logic [WIDTH-1:0] mem_d,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_q,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e           state_q, state_d;
    logic             owner_d_q;
    logic             rd_q;
    logic             we_q;
    logic [WIDTH-1:0] ad_q, wd_q;
    logic             gnt_d, gnt_i, any_gnt;

`ifdef MEM_ARB_RR_EN
    // 1 when the data side won the most recent grant
    logic             last_d_q;
`endif

    always_comb begin
        gnt_d   = 1'b0;
        gnt_i   = 1'b0;
        state_d = state_q;
        // A new grant may overlap the response phase of the previous access.
        if (!reset && state_q != StAccess) begin
`ifdef MEM_ARB_RR_EN
            if (d_req && if_req) begin
                gnt_d = !last_d_q;
                gnt_i = last_d_q;
            end else begin
                gnt_d = d_req;
                gnt_i = if_req;
            end
`else
            gnt_d = d_req;
            gnt_i = if_req && !d_req;
`endif
        end
        any_gnt = gnt_d || gnt_i;
        unique case (state_q)
            StIdle:   if (any_gnt) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = any_gnt ? StAccess : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_d_q <= 1'b0;
            rd_q      <= 1'b0;
            we_q      <= 1'b0;
            ad_q      <= '0;
            wd_q      <= '0;
        end else begin
            state_q <= state_d;
            // Only set on the grant cycle, so the strobe lasts exactly the ACCESS cycle.
            we_q    <= gnt_d && d_we;
            if (any_gnt) begin
                owner_d_q <= gnt_d;
                rd_q      <= !(gnt_d && d_we);
                ad_q      <= gnt_d ? d_addr : if_addr;
                if (gnt_d) wd_q <= d_wdata;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else if (any_gnt) begin
            last_d_q <= gnt_d;
        end
    end
`endif

    always_comb begin
        if_gnt    = gnt_i;
        d_gnt     = gnt_d;
        if_rvalid = !reset && state_q == StResp && rd_q && !owner_d_q;
        d_rvalid  = !reset && state_q == StResp && rd_q && owner_d_q;
        if_rdata  = mem_q;
        d_rdata   = mem_q;
        mem_ad    = ad_q;
        mem_d     = wd_q;
        mem_we    = we_q;
        busy      = state_q != StIdle;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Randomized and directed bench for mem_arb: RAM model, reference arbitration/memory model,
// and a negedge monitor that checks every cycle against a queue of expected read responses.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_ad, mem_d, mem_q;
    logic        mem_we, busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    mem_arb #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_ad    (mem_ad),
        .mem_d     (mem_d),
        .mem_we    (mem_we),
        .mem_q     (mem_q),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int idx);
        logic [31:0] v;
        if (idx == 4) return 32'hE3A01005;
        v = 32'(idx) * 32'h9E3779B9;
        return v ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronous RAM, read-first, one cycle read latency
    logic [31:0] ram [int];
    always @(posedge clk) begin : ram_model
        int ia;
        ia = int'(mem_ad[9:2]);
        mem_q <= ram.exists(ia) ? ram[ia] : init_val(ia);
        if (mem_we) ram[ia] = mem_d;
    end

    // Reference model: accesses complete in grant order, one grant at most every other cycle
    typedef struct {
        bit          src_d;
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [int];
    int          last_gnt = -100;
    int          we_cyc   = -100;
    bit          last_d   = 1'b0;
    bit          exp_wr   = 1'b0;
    logic [31:0] exp_ad, exp_md;

    always @(negedge clk) begin : monitor
        bit          allowed, ed, ei;
        int          idx;
        logic [31:0] rd;
        exp_t        e;
        if (reset) begin
            chk("gnt_in_reset", {30'd0, if_gnt, d_gnt}, 32'd0);
            chk("rvalid_in_reset", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            q.delete();
            last_gnt = -100;
            we_cyc   = -100;
            last_d   = 1'b0;
        end else begin
            allowed = (cyc != last_gnt + 1);
            ed = 1'b0;
            ei = 1'b0;
            if (allowed) begin
                if (d_req && if_req) begin
`ifdef MEM_ARB_RR_EN
                    ed = !last_d;
                    ei = last_d;
`else
                    ed = 1'b1;
`endif
                end else begin
                    ed = d_req;
                    ei = if_req;
                end
            end
            chk("d_gnt", {31'd0, d_gnt}, {31'd0, ed});
            chk("if_gnt", {31'd0, if_gnt}, {31'd0, ei});
            chk("busy", {31'd0, busy},
                {31'd0, (cyc == last_gnt + 1) || (cyc == last_gnt + 2)});
            chk("mem_we", {31'd0, mem_we}, {31'd0, cyc == we_cyc});
            if (cyc == last_gnt + 1) begin
                chk("mem_ad", mem_ad, exp_ad);
                if (exp_wr) chk("mem_d", mem_d, exp_md);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("rvalid_src", {30'd0, if_rvalid, d_rvalid}, e.src_d ? 32'd1 : 32'd2);
                chk("rdata", e.src_d ? d_rdata : if_rdata, e.data);
            end else begin
                chk("no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            end
            if (ed || ei) begin
                last_gnt = cyc;
                last_d   = ed;
                exp_ad   = ed ? d_addr : if_addr;
                exp_wr   = ed && d_we;
                exp_md   = d_wdata;
                idx      = int'(exp_ad[9:2]);
                if (exp_wr) begin
                    we_cyc       = cyc + 1;
                    ref_mem[idx] = d_wdata;
                end else begin
                    rd = ref_mem.exists(idx) ? ref_mem[idx] : init_val(idx);
                    q.push_back('{src_d: ed, due: cyc + 2, data: rd});
                end
            end
        end
    end

    task automatic do_reset();
        reset  = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Raise a request, hold until granted, drop it; returns 1 step into the ACCESS cycle.
    task automatic req_wait(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd);
        bit got;
        got = 1'b0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = is_d ? d_gnt : if_gnt;
            @(posedge clk);
            #1;
        end
        chk("grant_timeout", {31'd0, got}, 32'd1);
        if (is_d) d_req = 1'b0;
        else if_req = 1'b0;
    endtask

    initial begin
        bit gi, gd;
        int n;
        bit order [4];
        int gcyc [4];
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outputs", {26'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we, busy}, 32'd0);
        chk("rst_mem_ad", mem_ad, 32'd0);
        chk("rst_mem_d", mem_d, 32'd0);
        @(posedge clk);
        #1;

        // Fetch from preloaded address
        req_wait(1'b0, 1'b0, 32'h10, 32'd0);
        @(negedge clk);
        chk("fetch_mem_ad", mem_ad, 32'h10);
        chk("fetch_no_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("fetch_rdata", if_rdata, 32'hE3A01005);
        @(posedge clk);
        #1;

        // Write then read back
        req_wait(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_we", {31'd0, mem_we}, 32'd1);
        chk("wr_ad", mem_ad, 32'h40);
        chk("wr_d", mem_d, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("wr_we_one_cycle", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        req_wait(1'b1, 1'b0, 32'h40, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rd_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("rd_data", d_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Both masters requesting continuously
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h104;
        n = 0;
        for (int c = 0; c < 12 && n < 4; c++) begin
            @(negedge clk);
            if (d_gnt || if_gnt) begin
                order[n] = d_gnt;
                gcyc[n]  = cyc;
                n++;
            end
            if (n < 4) begin
                @(posedge clk);
                #1;
            end
        end
        chk("contend_count", n, 4);
        for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_RR_EN
            chk("contend_order", {31'd0, order[i]}, {31'd0, (i % 2) == 0});
`else
            chk("contend_order", {31'd0, order[i]}, 32'd1);
`endif
            if (i > 0) chk("contend_spacing", gcyc[i] - gcyc[i-1], 2);
        end
        @(posedge clk);
        #1;
        d_req = 1'b0; if_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during the ACCESS cycle of a write
        do_reset();
        req_wait(1'b1, 1'b1, 32'h80, 32'h12345678);
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        @(negedge clk);
        chk("abort_rvalid2", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        @(posedge clk);
        #1;

        // Fetch request withdrawn after losing to data in the RESP cycle
        do_reset();
        req_wait(1'b0, 1'b0, 32'h10, 32'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; if_req = 1'b1; if_addr = 32'h50;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wd_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("wd_if_gnt", {31'd0, if_gnt}, 32'd0);
        @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wd_no_fetch_gnt", {31'd0, if_gnt}, 32'd0);
            chk("wd_no_fetch_ram", {31'd0, mem_ad == 32'h50}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            gi = if_gnt;
            gd = d_gnt;
            @(posedge clk);
            #1;
            if (gi) if_req = 1'b0;
            if (gd) d_req = 1'b0;
            if (!if_req && $urandom_range(0, 3) != 0) begin
                if_req  = 1'b1;
                if_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (!d_req && $urandom_range(0, 3) != 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'($urandom_range(0, 255)) << 2;
                d_wdata = $urandom;
            end
        end
        @(negedge clk);
        gi = if_gnt;
        gd = d_gnt;
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
